// File: rtl/bit_serializer_if.sv
// Upstream word handshake for bit_serializer: parallel word plus valid/ready.
interface bit_serializer_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             in_ready;

    modport master (output in_data, output in_valid, input in_ready);
    modport slave  (input in_data, input in_valid, output in_ready);
endinterface

// File: rtl/bit_serializer.sv
// bit_serializer: parallel-in, serial-out stage, MSB first, gapless chaining
// of back-to-back words. Optional feature macro: SER_PARITY_EN appends one
// even-parity bit after the data bits of every word.
module bit_serializer #(
    parameter int WIDTH = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    bit_serializer_if.slave               up,
    output logic                          x,
    output logic                          x_valid,
    output logic                          busy,
    output logic [$clog2(WIDTH+2)-1:0]    bit_cnt
);
    localparam int CW = $clog2(WIDTH+2);
`ifdef SER_PARITY_EN
    localparam int F = WIDTH + 1;
`else
    localparam int F = WIDTH;
`endif
    localparam logic [CW-1:0] LAST = CW'(F - 1);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             x_q, x_d;
    logic             xv_q, xv_d;
    logic             last_bit;
    logic             accept;
    logic             fill;

    // Ready is a decode of registered state only; high on the final bit to allow chaining.
    assign last_bit    = (state_q == SHIFT) && (cnt_q == LAST);
    assign up.in_ready = (state_q == IDLE) || last_bit;
    assign accept      = up.in_valid && up.in_ready;

`ifdef SER_PARITY_EN
    logic parity_q;

    // Parity of the accepted word, fed into the LSB so it reaches the MSB after WIDTH shifts.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)      parity_q <= 1'b0;
        else if (accept) parity_q <= ^up.in_data;
    end
    assign fill = parity_q;
`else
    assign fill = 1'b0;
`endif

    // Next-state and next-output decode; outputs derived from the next shift value.
    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        cnt_d   = cnt_q;
        if (accept) begin
            state_d = SHIFT;
            shift_d = up.in_data;
            cnt_d   = '0;
        end else if (state_q == SHIFT) begin
            if (last_bit) begin
                state_d = IDLE;
                shift_d = '0;
                cnt_d   = '0;
            end else begin
                shift_d = {shift_q[WIDTH-2:0], fill};
                cnt_d   = cnt_q + CW'(1);
            end
        end
        xv_d = (state_d == SHIFT);
        x_d  = xv_d ? shift_d[WIDTH-1] : 1'b0;
    end

    // State and registered outputs; reset discards any partial frame.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            shift_q <= '0;
            cnt_q   <= '0;
            x_q     <= 1'b0;
            xv_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            x_q     <= x_d;
            xv_q    <= xv_d;
        end
    end

    assign x       = x_q;
    assign x_valid = xv_q;
    assign busy    = xv_q;
    assign bit_cnt = cnt_q;
endmodule

// File: tb/tb_bit_serializer.sv
// Testbench for bit_serializer: constant vector tables, directed corner
// sequences and randomized traffic against a frame-queue reference model.
module tb_bit_serializer;
    localparam int W  = 8;
    localparam int CW = $clog2(W+2);
`ifdef SER_PARITY_EN
    localparam int F = W + 1;
`else
    localparam int F = W;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          x, x_valid, busy;
    logic [CW-1:0] bit_cnt;
    int            tests = 0;
    int            fails = 0;

    bit_serializer_if #(.WIDTH(W)) bus ();

    bit_serializer #(.WIDTH(W)) dut (
        .clk     (clk),
        .reset   (reset),
        .up      (bus.slave),
        .x       (x),
        .x_valid (x_valid),
        .busy    (busy),
        .bit_cnt (bit_cnt)
    );

    always #5 clk = ~clk;

    // Reference model: the bits of the frame in flight, and which one is on x.
    int m_bits[$];
    int m_pos;

    function automatic logic m_ready();
        return (m_bits.size() == 0) || (m_pos == F - 1);
    endfunction

    task automatic m_edge(input logic acc, input logic [W-1:0] d);
        if (acc) begin
            m_bits.delete();
            for (int i = W - 1; i >= 0; i--) m_bits.push_back(int'(d[i]));
            if (F > W) m_bits.push_back(int'(^d));
            m_pos = 0;
            $display("[TB] accept word %h", d);
        end else if (m_bits.size() != 0) begin
            m_pos++;
            if (m_pos == F) m_bits.delete();
        end
    endtask

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_outputs_model();
        if (m_bits.size() != 0) begin
            chk("x", int'(x), m_bits[m_pos]);
            chk("x_valid", int'(x_valid), 1);
            chk("busy", int'(busy), 1);
            chk("bit_cnt", int'(bit_cnt), m_pos);
        end else begin
            chk("x_idle", int'(x), 0);
            chk("x_valid_idle", int'(x_valid), 0);
            chk("busy_idle", int'(busy), 0);
            chk("bit_cnt_idle", int'(bit_cnt), 0);
        end
    endtask

    // One clock with model checking; called at edge+1, returns at edge+1.
    task automatic apply(input logic v, input logic [W-1:0] d, output logic acc);
        logic er;
        bus.in_valid = v;
        bus.in_data  = d;
        #2;
        er = m_ready();
        chk("in_ready", int'(bus.in_ready), int'(er));
        @(posedge clk);
        acc = v & er;
        m_edge(acc, d);
        #1;
        chk_outputs_model();
    endtask

    typedef struct {
        logic         v;
        logic [W-1:0] d;
        logic         rdy;
        logic         x;
        logic         xv;
        int           cnt;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic v, input logic [W-1:0] d, input logic rdy,
                                input logic xx, input logic xv, input int cnt);
        vec_t r;
        r.v = v; r.d = d; r.rdy = rdy; r.x = xx; r.xv = xv; r.cnt = cnt;
        return r;
    endfunction

    initial begin
        logic         acc;
        logic         pend;
        logic [W-1:0] pdata;
        int           n;

        bus.in_valid = 1'b0;
        bus.in_data  = '0;

        // Reset held for three clocks, then released with no traffic.
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("rst_x", int'(x), 0);
            chk("rst_x_valid", int'(x_valid), 0);
            chk("rst_busy", int'(busy), 0);
            chk("rst_bit_cnt", int'(bit_cnt), 0);
            chk("rst_in_ready", int'(bus.in_ready), 1);
        end
        reset = 1'b1;
        m_bits.delete();
        m_pos = 0;
        apply(1'b0, '0, acc);
        apply(1'b0, '0, acc);

        // Constant vector table.
`ifdef SER_PARITY_EN
        tbl.push_back(mk(1, 8'h07, 1, 0, 1, 0));
        tbl.push_back(mk(0, 8'h00, 0, 0, 1, 1));
        tbl.push_back(mk(0, 8'h00, 0, 0, 1, 2));
        tbl.push_back(mk(0, 8'h00, 0, 0, 1, 3));
        tbl.push_back(mk(0, 8'h00, 0, 0, 1, 4));
        tbl.push_back(mk(0, 8'h00, 0, 1, 1, 5));
        tbl.push_back(mk(0, 8'h00, 0, 1, 1, 6));
        tbl.push_back(mk(0, 8'h00, 0, 1, 1, 7));
        tbl.push_back(mk(0, 8'h00, 0, 1, 1, 8));
        tbl.push_back(mk(1, 8'h03, 1, 0, 1, 0));
        tbl.push_back(mk(0, 8'h00, 0, 0, 1, 1));
        tbl.push_back(mk(0, 8'h00, 0, 0, 1, 2));
        tbl.push_back(mk(0, 8'h00, 0, 0, 1, 3));
        tbl.push_back(mk(0, 8'h00, 0, 0, 1, 4));
        tbl.push_back(mk(0, 8'h00, 0, 0, 1, 5));
        tbl.push_back(mk(0, 8'h00, 0, 1, 1, 6));
        tbl.push_back(mk(0, 8'h00, 0, 1, 1, 7));
        tbl.push_back(mk(0, 8'h00, 0, 0, 1, 8));
        tbl.push_back(mk(0, 8'h00, 1, 0, 0, 0));
        tbl.push_back(mk(0, 8'h00, 1, 0, 0, 0));
`else
        tbl.push_back(mk(1, 8'hB0, 1, 1, 1, 0));
        tbl.push_back(mk(0, 8'h00, 0, 0, 1, 1));
        tbl.push_back(mk(0, 8'h00, 0, 1, 1, 2));
        tbl.push_back(mk(0, 8'h00, 0, 1, 1, 3));
        tbl.push_back(mk(0, 8'h00, 0, 0, 1, 4));
        tbl.push_back(mk(0, 8'h00, 0, 0, 1, 5));
        tbl.push_back(mk(0, 8'h00, 0, 0, 1, 6));
        tbl.push_back(mk(0, 8'h00, 0, 0, 1, 7));
        tbl.push_back(mk(0, 8'h00, 1, 0, 0, 0));
        tbl.push_back(mk(0, 8'h00, 1, 0, 0, 0));
`endif
        foreach (tbl[i]) begin
            bus.in_valid = tbl[i].v;
            bus.in_data  = tbl[i].d;
            #2;
            chk($sformatf("tbl%0d_in_ready", i), int'(bus.in_ready), int'(tbl[i].rdy));
            @(posedge clk);
            m_edge(tbl[i].v & tbl[i].rdy, tbl[i].d);
            #1;
            chk($sformatf("tbl%0d_x", i), int'(x), int'(tbl[i].x));
            chk($sformatf("tbl%0d_x_valid", i), int'(x_valid), int'(tbl[i].xv));
            chk($sformatf("tbl%0d_busy", i), int'(busy), int'(tbl[i].xv));
            chk($sformatf("tbl%0d_bit_cnt", i), int'(bit_cnt), tbl[i].cnt);
        end

        // Back-to-back: A5 then 3C with valid held high.
        apply(1'b1, 8'hA5, acc);
        chk("b2b_first_accept", int'(acc), 1);
        n = 0;
        do begin
            apply(1'b1, 8'h3C, acc);
            n++;
        end while (!acc && n < 2 * F);
        chk("b2b_second_accept_cycle", n, F);
        for (int i = 0; i < F + 1; i++) apply(1'b0, '0, acc);

        // Stall: FF presented mid-frame of 00 must wait for the last bit.
        apply(1'b1, 8'h00, acc);
        for (int i = 0; i < 3; i++) apply(1'b0, '0, acc);
        n = 0;
        do begin
            apply(1'b1, 8'hFF, acc);
            n++;
        end while (!acc && n < 2 * F);
        chk("stall_accept_cycle", n, F - 3);
        for (int i = 0; i < F + 1; i++) apply(1'b0, '0, acc);

        // Asynchronous reset mid-frame of F0.
        apply(1'b1, 8'hF0, acc);
        for (int i = 0; i < 3; i++) apply(1'b0, '0, acc);
        chk("pre_rst_bit_cnt", int'(bit_cnt), 3);
        #2;
        reset = 1'b0;
        #1;
        chk("arst_x", int'(x), 0);
        chk("arst_x_valid", int'(x_valid), 0);
        chk("arst_busy", int'(busy), 0);
        chk("arst_bit_cnt", int'(bit_cnt), 0);
        chk("arst_in_ready", int'(bus.in_ready), 1);
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b1;
        m_bits.delete();
        m_pos = 0;
        apply(1'b1, 8'h81, acc);
        for (int i = 0; i < F + 1; i++) apply(1'b0, '0, acc);

        // Randomized traffic; a pending word is held until accepted.
        pend  = 1'b0;
        pdata = '0;
        for (int i = 0; i < 400; i++) begin
            if (!pend && ($urandom_range(0, 3) != 0)) begin
                pend  = 1'b1;
                pdata = W'($urandom);
            end
            apply(pend, pend ? pdata : W'($urandom), acc);
            if (acc) pend = 1'b0;
        end
        for (int i = 0; i < F + 2; i++) apply(1'b0, '0, acc);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/bit_serializer.md
Name: bit_serializer

Overview:
- Parallel-in, serial-out stage that sits directly upstream of the bit-serial sequence detector and drives its `x` input one bit per clock, MSB first.
- Accepts WIDTH-bit words over a valid/ready handshake.
- Back-to-back words stream with no idle gap, so the detector sees a contiguous bit stream across word boundaries.
- Reports whether the current serial bit is meaningful, so downstream can qualify its inputs.

Parameters:
- WIDTH, 8: data word width in bits; legal range is WIDTH >= 2.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- reset  input  1  asynchronous, active-low reset. Asserted (0) clears all state immediately, regardless of clk.
- in_data  input  WIDTH  parallel word to serialize; sampled only on the accept edge.
- in_valid  input  1  upstream has a word on in_data.
- in_ready  output  1  block can accept a word this cycle.
- x  output  1  serial data bit; feeds the detector's x input.
- x_valid  output  1  x carries a real data (or parity) bit this cycle.
- busy  output  1  a frame is in progress.
- bit_cnt  output  $clog2(WIDTH+2)  index of the bit currently on x, counting from 0 = MSB; 0 when idle.

Behaviour:
- States: IDLE, SHIFT.
- Frame length F = WIDTH, or WIDTH+1 with the optional feature.
- Reset (reset=0), asynchronous:
  - state=IDLE; shift register=0.
  - x=0, x_valid=0, busy=0, bit_cnt=0, in_ready=1.
  - Takes effect immediately; any partially sent word is discarded and is not resent.
- Accept = in_valid & in_ready at a rising clk edge. On accept:
  - shift register <= in_data; bit_cnt <= 0; state <= SHIFT.
- Latency: the first bit (in_data[WIDTH-1]) appears on x with x_valid=1 in the cycle after the accept edge.
- SHIFT:
  - Each edge shifts left by one and increments bit_cnt.
  - x = shift register MSB, x_valid=1, busy=1.
  - x_valid is high for exactly F consecutive cycles per word.
- in_ready = (state==IDLE) | (state==SHIFT & bit_cnt==F-1).
  - Ready is therefore high during the last bit of a frame, which allows gapless chaining.
- Last bit with accept: the next cycle shows bit 0 (MSB) of the new word; state stays SHIFT and bit_cnt returns to 0.
- Last bit without accept: state <= IDLE; the next cycle has x=0, x_valid=0, busy=0, bit_cnt=0.
- x is forced to 0 whenever x_valid=0. Downstream must qualify x with x_valid; the block does not insert gaps itself.
- in_valid while in_ready=0 is ignored: no capture, no effect on the current frame. Upstream must hold in_data and in_valid until accepted.
- in_data changes while not accepting have no effect.
- All outputs are registered, except in_ready, which is a combinational decode of registered state only (no path from in_valid).

Optional Feature:
- Macro: SER_PARITY_EN.
- Defined:
  - One parity bit is appended after the WIDTH data bits, so F = WIDTH+1.
  - The parity bit equals the XOR of all WIDTH bits of the accepted word (even parity over data+parity).
  - It is computed and registered at accept time.
  - x_valid stays high during the parity bit.
  - in_ready is asserted during the parity bit, not during data bit WIDTH-1.
- Undefined:
  - No parity bit; F = WIDTH.
  - No parity logic is present.

Test Plan:
1. Reset: hold reset=0 for 3 clk, then release with in_valid=0 -> x=0, x_valid=0, busy=0, bit_cnt=0, in_ready=1 throughout and after release.
2. Single word: accept 8'hB0, in_valid dropped next cycle -> x = 1,0,1,1,0,0,0,0 on cycles 1-8 after accept, with x_valid=1 and bit_cnt 0..7. Cycle 9: x_valid=0, busy=0.
3. Back-to-back: accept 8'hA5 with in_valid held high and in_data switching to 8'h3C after accept -> 16 contiguous valid bits 1010_0101_0011_1100. in_ready is high only at cycle 0 (IDLE) and at bit_cnt=7 of the first word; x_valid never drops between the words.
4. Stall: present 8'hFF with in_valid=1 at bit_cnt=3 of word 8'h00 -> ignored until bit_cnt=7. 8'h00 completes unchanged (eight 0s), then eight 1s follow with no gap.
5. Reset mid-frame: assert reset=0 asynchronously (between edges) while bit_cnt=3 of 8'hF0 -> x_valid, x, busy drop to 0 before the next edge. After release, accept 8'h81 -> bits 1,0,0,0,0,0,0,1 with no residue from 8'hF0.
6. SER_PARITY_EN defined:
   - Accept 8'h07 -> 9 valid bits 0000_0111 then parity 1; in_ready high only at bit_cnt=8.
   - Accept 8'h03 -> parity 0.
